// File: rtl/twoclock_unfifo_warb_pkg.sv
// Shared types and defaults for the twoclock_unfifo write-side arbiter.
package twoclock_unfifo_warb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_e;

    localparam int DEF_DSIZE = 16;
    localparam int DEF_NREQ  = 4;
    localparam int DEF_CW    = 16;

    // Index width for n requesters; a single bit even when n <= 2.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/twoclock_unfifo_warb_rr_pick.sv
// Combinational round-robin picker: masked requesters win outright (lowest index),
// the rest are searched upward from ptr_i with wrap at NREQ.
module twoclock_unfifo_warb_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic [NREQ-1:0] prio_i,
    output logic [IDW-1:0]  win_o,
    output logic            valid_o
);

    logic [NREQ-1:0]   hi_req;
    logic [NREQ-1:0]   rr_req;
    logic [2*NREQ-1:0] rot;
    int                w;

    always_comb begin
        hi_req  = req_i & prio_i;
        rr_req  = req_i & ~prio_i;
        rot     = {rr_req, rr_req} >> ptr_i;
        valid_o = |req_i;
        win_o   = '0;
        w       = 0;
        if (|hi_req) begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (hi_req[i]) win_o = IDW'(i);
            end
        end else begin
            // Descending scan so the nearest set bit after ptr_i is written last.
            for (int i = NREQ - 1; i >= 0; i--) begin
                if (rot[i]) begin
                    w = int'(ptr_i) + i;
                    if (w >= NREQ) w = w - NREQ;
                    win_o = IDW'(w);
                end
            end
        end
    end

endmodule

// File: rtl/twoclock_unfifo_warb.sv
// Round-robin write arbiter feeding one twoclock_unfifo write port with {source, payload}.
// Optional TWOCLOCK_UNFIFO_WARB_PRIO_EN: requester 0 gets strict priority and leaves ptr alone.
module twoclock_unfifo_warb
    import twoclock_unfifo_warb_pkg::*;
#(
    parameter  int DSIZE = DEF_DSIZE,
    parameter  int NREQ  = DEF_NREQ,
    parameter  int CW    = DEF_CW,
    localparam int IDW   = clog2_min1(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst_i,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*DSIZE-1:0] data_i,
    output logic [NREQ-1:0]       ack_o,
    output logic                  winc_o,
    output logic [IDW+DSIZE-1:0]  wdata_o,
    input  logic                  wfull_i,
    output logic                  busy_o,
    output logic [CW-1:0]         wcount_o
);

    state_e               state_q, state_d;
    logic                 winc_q, winc_d;
    logic [IDW+DSIZE-1:0] wdata_q, wdata_d;
    logic [IDW-1:0]       grant_q, grant_d;
    logic [IDW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]        wcount_q, wcount_d;

    logic [DSIZE-1:0]     data_a [NREQ];
    logic [NREQ-1:0]      prio_mask;
    logic [IDW-1:0]       pick_win;
    logic                 pick_vld;
    logic                 accept;
    logic [IDW-1:0]       next_ptr;

    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign data_a[k] = data_i[k*DSIZE +: DSIZE];
    end

`ifdef TWOCLOCK_UNFIFO_WARB_PRIO_EN
    assign prio_mask = NREQ'(1);
`else
    assign prio_mask = '0;
`endif

    twoclock_unfifo_warb_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .prio_i  (prio_mask),
        .win_o   (pick_win),
        .valid_o (pick_vld)
    );

    assign accept = (state_q == OFFER) && winc_q && !wfull_i;

    always_comb begin
        next_ptr = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + IDW'(1);
`ifdef TWOCLOCK_UNFIFO_WARB_PRIO_EN
        if (grant_q == '0) next_ptr = ptr_q;
`endif
    end

    // State register
    always_ff @(posedge wclk) begin
        if (wrst_i) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = OFFER;
            OFFER:   if (accept)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant/datapath next values; grant stays locked for the whole OFFER.
    always_comb begin
        winc_d   = winc_q;
        wdata_d  = wdata_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        wcount_d = wcount_q;
        if (state_q == IDLE && pick_vld) begin
            winc_d  = 1'b1;
            grant_d = pick_win;
            wdata_d = {pick_win, data_a[pick_win]};
        end
        if (accept) begin
            winc_d   = 1'b0;
            ptr_d    = next_ptr;
            wcount_d = wcount_q + CW'(1);
        end
    end

    always_ff @(posedge wclk) begin
        if (wrst_i) begin
            winc_q   <= 1'b0;
            wdata_q  <= '0;
            grant_q  <= '0;
            ptr_q    <= '0;
            wcount_q <= '0;
        end else begin
            winc_q   <= winc_d;
            wdata_q  <= wdata_d;
            grant_q  <= grant_d;
            ptr_q    <= ptr_d;
            wcount_q <= wcount_d;
        end
    end

    // Outputs
    always_comb begin
        ack_o    = accept ? (NREQ'(1) << grant_q) : '0;
        busy_o   = (state_q != IDLE);
        winc_o   = winc_q;
        wdata_o  = wdata_q;
        wcount_o = wcount_q;
    end

endmodule

// File: tb/tb_twoclock_unfifo_warb.sv
// Scoreboard bench for twoclock_unfifo_warb (CW=4 so the counter wrap is reachable).
module tb_twoclock_unfifo_warb;

    localparam int DSIZE = 16;
    localparam int NREQ  = 4;
    localparam int CW    = 4;
    localparam int IDW   = 2;

    logic                  wclk = 1'b0;
    logic                  wrst_i = 1'b1;
    logic [NREQ-1:0]       req_i = '0;
    logic [NREQ*DSIZE-1:0] data_i = '0;
    logic [NREQ-1:0]       ack_o;
    logic                  winc_o;
    logic [IDW+DSIZE-1:0]  wdata_o;
    logic                  wfull_i = 1'b0;
    logic                  busy_o;
    logic [CW-1:0]         wcount_o;

    int total = 0;
    int bad   = 0;
    logic [IDW+DSIZE-1:0] sb [$];
    logic [IDW+DSIZE-1:0] exp_w;
    logic [CW-1:0]        exp_cnt;

    twoclock_unfifo_warb #(.DSIZE(DSIZE), .NREQ(NREQ), .CW(CW)) dut (
        .wclk     (wclk),
        .wrst_i   (wrst_i),
        .req_i    (req_i),
        .data_i   (data_i),
        .ack_o    (ack_o),
        .winc_o   (winc_o),
        .wdata_o  (wdata_o),
        .wfull_i  (wfull_i),
        .busy_o   (busy_o),
        .wcount_o (wcount_o)
    );

    always #5 wclk = ~wclk;

    always @(negedge wclk) begin
        if (!wrst_i) begin
            total++;
            if (!$onehot0(ack_o)) begin
                bad++;
                $display("FAIL ack_onehot: ack_o=%b", ack_o);
            end
        end
    end

    task automatic do_reset();
        @(negedge wclk);
        wrst_i  = 1'b1;
        req_i   = '0;
        wfull_i = 1'b0;
        repeat (2) @(negedge wclk);
        wrst_i  = 1'b0;
        exp_cnt = '0;
        sb.delete();
    endtask

    task automatic set_data(input int k, input logic [DSIZE-1:0] v);
        data_i[k*DSIZE +: DSIZE] = v;
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (winc_o !== 1'b0)   begin bad++; $display("FAIL reset_winc: got %b want 0", winc_o); end
        if (wdata_o !== '0)    begin bad++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
        if (ack_o !== '0)      begin bad++; $display("FAIL reset_ack: got %b want 0", ack_o); end
        if (busy_o !== 1'b0)   begin bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        if (wcount_o !== '0)   begin bad++; $display("FAIL reset_wcount: got %0d want 0", wcount_o); end
    endtask

    task automatic test_single();
        do_reset();
        set_data(2, 16'hBEEF);
        req_i = 4'b0100;
        sb.push_back({2'd2, 16'hBEEF});
        @(negedge wclk);
        total += 2;
        if (winc_o !== 1'b1) begin bad++; $display("FAIL single_winc: got %b want 1", winc_o); end
        if (busy_o !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy_o); end
        if (sb.size() == 0 || ack_o === '0) begin
            total++; bad++; $display("FAIL single_ack: got ack=%b want 0100", ack_o);
        end else begin
            exp_w = sb.pop_front();
            total += 2;
            if (wdata_o !== exp_w) begin bad++; $display("FAIL single_wdata: got %h want %h", wdata_o, exp_w); end
            if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL single_ackbit: got %b want 0100", ack_o); end
        end
        req_i = '0;
        exp_cnt++;
        @(negedge wclk);
        total += 4;
        if (wcount_o !== exp_cnt) begin bad++; $display("FAIL single_wcount: got %0d want %0d", wcount_o, exp_cnt); end
        if (winc_o !== 1'b0)      begin bad++; $display("FAIL single_winc_off: got %b want 0", winc_o); end
        if (ack_o !== '0)         begin bad++; $display("FAIL single_ack_off: got %b want 0", ack_o); end
        if (busy_o !== 1'b0)      begin bad++; $display("FAIL single_idle: got %b want 0", busy_o); end
    endtask

    task automatic test_round_robin();
        logic [DSIZE-1:0] d [NREQ];
        logic [NREQ-1:0]  rearm;
        int order [6] = '{0, 1, 2, 3, 0, 1};
        int got [$];
        int acks, k;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            d[i] = 16'h1000 + 16'(i * 256);
            set_data(i, d[i]);
        end
        for (int i = 0; i < 6; i++)
            sb.push_back({IDW'(order[i]), d[order[i]] + DSIZE'(i / 4)});
        rearm = '0;
        req_i = '1;
        acks  = 0;
        for (int cyc = 0; cyc < 100 && acks < 6; cyc++) begin
            @(negedge wclk);
            req_i = req_i | rearm;
            rearm = '0;
            if (ack_o !== '0) begin
                k = 0;
                for (int b = 0; b < NREQ; b++) if (ack_o[b]) k = b;
                got.push_back(k);
                if (sb.size() == 0) begin
                    total++; bad++; $display("FAIL rr_extra_ack: got ack=%b", ack_o);
                end else begin
                    exp_w = sb.pop_front();
                    total += 2;
                    if (wdata_o !== exp_w) begin bad++; $display("FAIL rr_wdata: got %h want %h", wdata_o, exp_w); end
                    if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL rr_order: got ack=%b want idx %0d", ack_o, exp_w[DSIZE +: IDW]); end
                end
                acks++;
                exp_cnt++;
                d[k] = d[k] + 1'b1;
                set_data(k, d[k]);
                req_i[k] = 1'b0;
                rearm[k] = 1'b1;
            end
        end
        req_i = '0;
        total++;
        if (acks != 6) begin bad++; $display("FAIL rr_timeout: got %0d acks want 6", acks); end
        for (int i = 0; i + 3 < got.size(); i++) begin
            total++;
            if (got[i] == got[i+1] || got[i] == got[i+2] || got[i] == got[i+3] ||
                got[i+1] == got[i+2] || got[i+1] == got[i+3] || got[i+2] == got[i+3]) begin
                bad++; $display("FAIL rr_fair: window %0d has %0d %0d %0d %0d, want distinct", i, got[i], got[i+1], got[i+2], got[i+3]);
            end
        end
        repeat (2) @(negedge wclk);
        total++;
        if (wcount_o !== exp_cnt) begin bad++; $display("FAIL rr_wcount: got %0d want %0d", wcount_o, exp_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        wfull_i = 1'b1;
        set_data(3, 16'h3333);
        req_i = 4'b1000;
        sb.push_back({2'd3, 16'h3333});
        @(negedge wclk);
        for (int i = 0; i < 20; i++) begin
            total += 3;
            if (winc_o !== 1'b1)                begin bad++; $display("FAIL bp_winc: cycle %0d got %b want 1", i, winc_o); end
            if (wdata_o !== {2'd3, 16'h3333})   begin bad++; $display("FAIL bp_wdata: cycle %0d got %h want 33333", i, wdata_o); end
            if (ack_o !== '0)                   begin bad++; $display("FAIL bp_ack: cycle %0d got %b want 0", i, ack_o); end
            @(negedge wclk);
        end
        wfull_i = 1'b0;
        #1;
        if (sb.size() == 0 || ack_o === '0) begin
            total++; bad++; $display("FAIL bp_release_ack: got ack=%b want 1000", ack_o);
        end else begin
            exp_w = sb.pop_front();
            total += 2;
            if (wdata_o !== exp_w) begin bad++; $display("FAIL bp_release_wdata: got %h want %h", wdata_o, exp_w); end
            if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL bp_release_ackbit: got %b want 1000", ack_o); end
        end
        req_i = '0;
        exp_cnt++;
        @(negedge wclk);
        total += 2;
        if (wcount_o !== exp_cnt) begin bad++; $display("FAIL bp_wcount: got %0d want %0d", wcount_o, exp_cnt); end
        if (ack_o !== '0)         begin bad++; $display("FAIL bp_single_ack: got %b want 0", ack_o); end
    endtask

    task automatic test_reset_mid_offer();
        do_reset();
        // Move the pointer to 2 first so a surviving pointer would show up later.
        set_data(1, 16'h1111);
        req_i = 4'b0010;
        sb.push_back({2'd1, 16'h1111});
        @(negedge wclk);
        if (sb.size() == 0 || ack_o === '0) begin
            total++; bad++; $display("FAIL rmo_pre_ack: got ack=%b want 0010", ack_o);
        end else begin
            exp_w = sb.pop_front();
            total++;
            if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL rmo_pre_ackbit: got %b want 0010", ack_o); end
        end
        req_i = '0;
        @(negedge wclk);
        wfull_i = 1'b1;
        set_data(2, 16'h2222);
        req_i = 4'b0100;
        @(negedge wclk);
        total++;
        if (winc_o !== 1'b1) begin bad++; $display("FAIL rmo_offer: got winc=%b want 1", winc_o); end
        wrst_i = 1'b1;
        req_i  = '0;
        @(negedge wclk);
        total += 5;
        if (winc_o !== 1'b0)  begin bad++; $display("FAIL rmo_winc: got %b want 0", winc_o); end
        if (wdata_o !== '0)   begin bad++; $display("FAIL rmo_wdata: got %h want 0", wdata_o); end
        if (ack_o !== '0)     begin bad++; $display("FAIL rmo_ack: got %b want 0", ack_o); end
        if (wcount_o !== '0)  begin bad++; $display("FAIL rmo_wcount: got %0d want 0", wcount_o); end
        if (busy_o !== 1'b0)  begin bad++; $display("FAIL rmo_busy: got %b want 0", busy_o); end
        wrst_i  = 1'b0;
        wfull_i = 1'b0;
        exp_cnt = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk);
            total++;
            if (ack_o !== '0) begin bad++; $display("FAIL rmo_dropped_ack: cycle %0d got %b want 0", i, ack_o); end
        end
        for (int i = 0; i < NREQ; i++) set_data(i, 16'hA000 + 16'(i));
        req_i = '1;
        sb.push_back({2'd0, 16'hA000});
        @(negedge wclk);
        if (sb.size() == 0 || ack_o === '0) begin
            total++; bad++; $display("FAIL rmo_ptr_ack: got ack=%b want 0001", ack_o);
        end else begin
            exp_w = sb.pop_front();
            total += 2;
            if (wdata_o !== exp_w) begin bad++; $display("FAIL rmo_ptr_wdata: got %h want %h", wdata_o, exp_w); end
            if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL rmo_ptr: got ack=%b want 0001", ack_o); end
        end
        req_i = '0;
        exp_cnt++;
        @(negedge wclk);
        total++;
        if (wcount_o !== exp_cnt) begin bad++; $display("FAIL rmo_post_wcount: got %0d want %0d", wcount_o, exp_cnt); end
    endtask

    task automatic test_counter_wrap();
        int k;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            k = i % NREQ;
            set_data(k, DSIZE'(i));
            req_i = NREQ'(1) << k;
            sb.push_back({IDW'(k), DSIZE'(i)});
            @(negedge wclk);
            if (sb.size() == 0 || ack_o === '0) begin
                total++; bad++; $display("FAIL wrap_ack: write %0d got ack=%b", i, ack_o);
            end else begin
                exp_w = sb.pop_front();
                total += 2;
                if (wdata_o !== exp_w) begin bad++; $display("FAIL wrap_wdata: write %0d got %h want %h", i, wdata_o, exp_w); end
                if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL wrap_ackbit: write %0d got %b", i, ack_o); end
            end
            req_i = '0;
            exp_cnt++;
            @(negedge wclk);
            if (i == 15) begin
                total++;
                if (wcount_o !== 4'd0) begin bad++; $display("FAIL wrap_zero: got %0d want 0", wcount_o); end
            end
        end
        total++;
        if (wcount_o !== 4'd1) begin bad++; $display("FAIL wrap_count: got %0d want 1", wcount_o); end
    endtask

    task automatic test_prio();
        logic [DSIZE-1:0] d [NREQ];
        logic [NREQ-1:0]  rearm;
        int acks, k;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            d[i] = 16'h5000 + 16'(i * 256);
            set_data(i, d[i]);
        end
`ifdef TWOCLOCK_UNFIFO_WARB_PRIO_EN
        for (int i = 0; i < 4; i++) sb.push_back({2'd0, d[0] + DSIZE'(i)});
`else
        for (int i = 0; i < 4; i++) sb.push_back({IDW'(i), d[i]});
`endif
        rearm = '0;
        req_i = '1;
        acks  = 0;
        for (int cyc = 0; cyc < 60 && acks < 4; cyc++) begin
            @(negedge wclk);
            req_i = req_i | rearm;
            rearm = '0;
            if (ack_o !== '0) begin
                k = 0;
                for (int b = 0; b < NREQ; b++) if (ack_o[b]) k = b;
                if (sb.size() == 0) begin
                    total++; bad++; $display("FAIL prio_extra_ack: got ack=%b", ack_o);
                end else begin
                    exp_w = sb.pop_front();
                    total += 2;
                    if (wdata_o !== exp_w) begin bad++; $display("FAIL prio_wdata: got %h want %h", wdata_o, exp_w); end
                    if (ack_o !== (NREQ'(1) << exp_w[DSIZE +: IDW])) begin bad++; $display("FAIL prio_order: got ack=%b want idx %0d", ack_o, exp_w[DSIZE +: IDW]); end
                end
                acks++;
                d[k] = d[k] + 1'b1;
                set_data(k, d[k]);
                // Requester 0 stays high with fresh data; the others take one cycle off.
                if (k != 0) begin
                    req_i[k] = 1'b0;
                    rearm[k] = 1'b1;
                end
            end
        end
        req_i = '0;
        total++;
        if (acks != 4) begin bad++; $display("FAIL prio_timeout: got %0d acks want 4", acks); end
        repeat (2) @(negedge wclk);
    endtask

    initial begin
        exp_cnt = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid_offer();
        test_counter_wrap();
        test_prio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
